// File: rtl/spi_write_arbiter.sv
// Round-robin arbiter sharing one single-shot SPI write engine among N_REQ requesters.
// One transaction in flight at a time. Hung transactions are ended by a WAIT-state timeout.
module spi_write_arbiter #(
  parameter int N_REQ          = 4,
  parameter int REG_WIDTH      = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*REG_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       eng_new_command,
  output logic                       eng_is_write,
  output logic [REG_WIDTH-1:0]       eng_register_addr,
  output logic [DATA_W-1:0]          eng_write_data,
  input  logic [DATA_W-1:0]          eng_data_read,
  input  logic                       eng_transaction_complete,
  output logic                       busy,
  output logic [7:0]                 timeout_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [REG_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [7:0]           tcnt_q, tcnt_d;
  logic                 is_write_q, is_write_d;

  // Rotating-priority search starting just after the last granted requester
  logic          arb_hit;
  logic [IW-1:0] arb_idx;
  int            cand;
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(last_q) + 1 + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!arb_hit && req_valid[IW'(cand)]) begin
        arb_hit = 1'b1;
        arb_idx = IW'(cand);
      end
    end
  end

  assign req_ready = (state_q == IDLE && arb_hit) ? (N_REQ'(1) << arb_idx) : '0;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    data_d     = data_q;
    timer_d    = timer_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    tcnt_d     = tcnt_q;
    is_write_d = is_write_q;
    case (state_q)
      IDLE: begin
        if (arb_hit) begin
          grant_d    = arb_idx;
          addr_d     = req_addr[int'(arb_idx)*REG_WIDTH +: REG_WIDTH];
          data_d     = req_data[int'(arb_idx)*DATA_W +: DATA_W];
          is_write_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        // A completion landing on the timeout cycle still counts as success
        if (eng_transaction_complete) begin
          rsp_data_d = eng_data_read;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (timer_q == TMAX) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d    = RESP;
        end
      end
      RESP: begin
        last_d     = grant_q;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        is_write_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      last_q     <= IW'(N_REQ - 1);
      grant_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      timer_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      tcnt_q     <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      tcnt_q     <= tcnt_d;
      is_write_q <= is_write_d;
    end
  end

  assign eng_new_command   = (state_q == ISSUE);
  assign eng_is_write      = is_write_q;
  assign eng_register_addr = addr_q;
  assign eng_write_data    = data_q;
  assign rsp_valid         = (state_q == RESP) ? (N_REQ'(1) << grant_q) : '0;
  assign rsp_data          = rsp_data_q;
  assign rsp_err           = rsp_err_q;
  assign busy              = (state_q != IDLE);
  assign timeout_count     = tcnt_q;

endmodule

// File: doc/spi_write_arbiter.md
Name: spi_write_arbiter

Overview:
Shares one SPI write engine (single-shot address + data shift, rising-edge-triggered start, one-cycle completion pulse) between N_REQ independent requesters. Round-robin arbitration, one transaction in flight at a time. Generates the engine start pulse, returns the captured read-back data to the granting requester, and times out hung transactions. Sits between the board control/register logic and the SPI driver.

Parameters:
N_REQ, 4, number of requesters (2..8)
REG_WIDTH, 8, address width in bits; also the engine register width
DATA_W, 8, write/read data width; equals REG_WIDTH*(MSG_LEN-1) of the engine
TIMEOUT_CYCLES, 1024, WAIT-state cycles before a transaction is declared failed (must be >= 2)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request pending; held until accepted
req_addr  in  N_REQ*REG_WIDTH  packed register addresses; requester i at [i*REG_WIDTH +: REG_WIDTH]
req_data  in  N_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  one-hot accept, combinational; a transfer occurs when req_valid[i] && req_ready[i]
rsp_valid  out  N_REQ  one-hot, one-cycle response strobe to the owning requester
rsp_data  out  DATA_W  read-back data, valid while any rsp_valid bit is high
rsp_err  out  1  timeout flag, valid while any rsp_valid bit is high
eng_new_command  out  1  engine start, one-cycle pulse
eng_is_write  out  1  engine write qualifier
eng_register_addr  out  REG_WIDTH  engine address
eng_write_data  out  DATA_W  engine write data
eng_data_read  in  DATA_W  engine read-back data
eng_transaction_complete  in  1  engine one-cycle done pulse
busy  out  1  high in every state except IDLE
timeout_count  out  8  saturating count of timed-out transactions

Behaviour:
- Reset (async): state=IDLE; last_grant=N_REQ-1, so requester 0 wins first; all outputs 0; timer and timeout_count 0. Reset mid-transaction abandons it and no response is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready = one-hot of the first set req_valid bit, searching from (last_grant+1) mod N_REQ upward with wrap. req_ready is 0 when no request is pending and in all other states.
  - On accept: register grant index g, addr and data into holding registers, then go to ISSUE.
  - An eng_transaction_complete arriving in IDLE is ignored.
- ISSUE (exactly 1 cycle): eng_new_command=1 and eng_is_write=1, both registered. Clear timer. Go to WAIT.
- WAIT: eng_new_command=0. eng_register_addr and eng_write_data remain driven from the holding registers in all states, stable from ISSUE until leaving RESP. Timer increments each cycle.
  - eng_transaction_complete=1: register rsp_data<=eng_data_read and rsp_err<=0. Go to RESP.
  - Otherwise, when timer==TIMEOUT_CYCLES-1: rsp_data<=0, rsp_err<=1, timeout_count increments and saturates at 255. Go to RESP.
  - If complete and timeout occur in the same cycle, complete wins.
- RESP (exactly 1 cycle): rsp_valid[g]=1. last_grant<=g. Go to IDLE. rsp_valid, rsp_data and rsp_err return to 0 on the following cycle.
- Timing:
  - Accept cycle T: eng_new_command high in cycle T+1.
  - Completion sampled in cycle C: rsp_valid high in cycle C+1.
  - Earliest next accept: C+2. This guarantees eng_new_command is low for at least 2 cycles between starts, which the engine's edge detection requires.
- Fairness: the granted requester has lowest priority at the next arbitration. A requester dropping req_valid before accept is legal; the arbiter reconsiders every IDLE cycle.
- After a timeout the engine may still be active. The arbiter continues regardless; recovery is software's responsibility via timeout_count.

Test Plan:
- Reset, then req_valid=4'b0001, addr0=8'h12, data0=8'hA5 -> req_ready=4'b0001 same cycle; eng_new_command high 1 cycle with addr 8'h12, data 8'hA5. Model returns 8'h3C -> rsp_valid=4'b0001, rsp_data=8'h3C, rsp_err=0.
- All four req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3. Exactly one eng_new_command pulse per transaction; no overlap.
- Engine model never completes, TIMEOUT_CYCLES=16 -> rsp_valid exactly 16 cycles after leaving ISSUE, rsp_err=1, rsp_data=0, timeout_count=1. The next request is still served normally.
- Completion pulse on the same cycle the timer reaches 15 -> rsp_err=0 and timeout_count unchanged.
- Assert rstn low during WAIT -> all outputs 0 immediately. After release, req_valid=4'b1010 -> requester 1 granted first.
- Stray eng_transaction_complete in IDLE -> no rsp_valid, state unchanged. Check eng_new_command low for >=2 cycles between back-to-back transactions.
